// File: rtl/nibble_feeder.sv
// nibble_feeder: FIFO-buffered nibble source feeding an accumulator in framed bursts.
// Optional NIBBLE_FEEDER_ZERO_SKIP_EN: zero nibbles are consumed without being fed or counted.
module nibble_feeder #(
  parameter int DEPTH = 4,
  parameter int FRAME_LEN = 8
) (
  input  logic clk,
  input  logic Rst,
  input  logic [3:0] in_data,
  input  logic in_valid,
  output logic in_ready,
  input  logic hold,
  output logic [3:0] ln,
  output logic acc_en,
  output logic acc_clr,
  output logic frame_done,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [7:0] LAST = 8'(FRAME_LEN - 1);
  typedef enum logic [1:0] {IDLE, CLEAR, FEED, DONE} state_t;
  state_t state;
  logic [3:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [7:0] fcnt;
  logic full, empty, push, pop, counted;
  assign full = fill_level == FULL;
  assign empty = fill_level == '0;
  assign in_ready = !full && !Rst;
  assign push = in_valid && in_ready;
  assign pop = state == FEED && !empty && !hold;
`ifdef NIBBLE_FEEDER_ZERO_SKIP_EN
  assign counted = pop && mem[rp] != 4'd0;
`else
  assign counted = pop;
`endif
  assign acc_clr = state == CLEAR;
  assign frame_done = state == DONE;
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    if (push) mem[wp] <= in_data;
  always_ff @(posedge clk) begin
    if (Rst) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      fill_level <= '0;
      fcnt <= '0;
      ln <= '0;
      acc_en <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      fill_level <= push && !pop ? fill_level + ONE : pop && !push ? fill_level - ONE : fill_level;
      acc_en <= counted;
      if (counted) ln <= mem[rp];
      case (state)
        IDLE: if (!empty) state <= CLEAR;
        CLEAR: begin
          fcnt <= '0;
          state <= FEED;
        end
        FEED: if (counted) begin
          fcnt <= fcnt + 8'd1;
          if (fcnt == LAST) state <= DONE;
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_feeder.sv
// tb_nibble_feeder: directed checks of framing, backpressure, reset and zero handling.
module tb_nibble_feeder;
  logic clk = 0, Rst = 1, in_valid = 0, hold = 0;
  logic [3:0] in_data = 0;
  logic in_ready, acc_en, acc_clr, frame_done, busy;
  logic [3:0] ln;
  logic [2:0] fill_level;
  int checks = 0, errors = 0;
  int sum = 0, fen = 0, idle_run = 0, min_gap = 99, clr_cnt = 0;
  bit after_done = 0;
  logic [31:0] log_r = 0;
  int sums[$], ens[$];
  logic [31:0] logs[$];
  always #5 clk = ~clk;
  nibble_feeder #(.DEPTH(4), .FRAME_LEN(8)) dut (
    .clk(clk), .Rst(Rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .hold(hold), .ln(ln), .acc_en(acc_en), .acc_clr(acc_clr), .frame_done(frame_done),
    .fill_level(fill_level), .busy(busy)
  );
  // Reference accumulator plus frame log, sampled mid-cycle.
  always @(negedge clk) begin
    if (acc_clr) begin
      sum = 0;
      fen = 0;
      clr_cnt++;
    end
    if (acc_en) begin
      sum += int'(ln);
      fen++;
      log_r = {log_r[27:0], ln};
      if (after_done && idle_run < min_gap) min_gap = idle_run;
      after_done = 0;
      idle_run = 0;
    end else idle_run++;
    if (frame_done) begin
      sums.push_back(sum);
      ens.push_back(fen);
      logs.push_back(log_r);
      after_done = 1;
    end
  end
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic clear_mon();
    sums.delete();
    ens.delete();
    logs.delete();
    clr_cnt = 0;
    min_gap = 99;
    after_done = 0;
  endtask
  task automatic push(input logic [3:0] d);
    in_valid = 1;
    in_data = d;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin
        tick(1);
        return;
      end
      tick(1);
    end
    check("push_timeout", 0, 1);
  endtask
  task automatic wait_frames(input int n);
    for (int i = 0; i < 300 && sums.size() < n; i++) tick(1);
    check("frames_seen", sums.size(), n);
    tick(2);
  endtask
  task automatic reset_outputs(input string tag);
    check({tag, "_ln"}, int'(ln), 0);
    check({tag, "_acc_en"}, int'(acc_en), 0);
    check({tag, "_acc_clr"}, int'(acc_clr), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_fill"}, int'(fill_level), 0);
    check({tag, "_in_ready"}, int'(in_ready), 0);
  endtask
  initial begin
    tick(3);
    reset_outputs("rst");
    Rst = 0;
    tick(1);
    check("ready_after_rst", int'(in_ready), 1);
    clear_mon();
    for (int i = 1; i <= 8; i++) push(4'(i));
    in_valid = 0;
    wait_frames(1);
    check("t1_clr", clr_cnt, 1);
    check("t1_en", sums.size() > 0 ? ens[0] : -1, 8);
    check("t1_log", sums.size() > 0 ? int'(logs[0]) : -1, 32'h12345678);
    check("t1_sum", sums.size() > 0 ? sums[0] : -1, 36);
    clear_mon();
    hold = 1;
    for (int i = 0; i < 4; i++) push(4'hF);
    tick(3);
    check("t2_full_fill", int'(fill_level), 4);
    check("t2_full_ready", int'(in_ready), 0);
    check("t2_no_en", fen, 0);
    check("t2_busy", int'(busy), 1);
    hold = 0;
    tick(1);
    check("t2_pop_at_full_fill", int'(fill_level), 3);
    check("t2_ready_again", int'(in_ready), 1);
    for (int i = 0; i < 4; i++) push(4'hF);
    in_valid = 0;
    wait_frames(1);
    check("t2_en", sums.size() > 0 ? ens[0] : -1, 8);
    check("t2_log", sums.size() > 0 ? int'(logs[0]) : -1, 32'hFFFFFFFF);
    check("t2_sum", sums.size() > 0 ? sums[0] : -1, 120);
    clear_mon();
    for (int i = 0; i < 16; i++) push(4'h3);
    in_valid = 0;
    wait_frames(2);
    check("t3_clr", clr_cnt, 2);
    check("t3_sum0", sums.size() > 0 ? sums[0] : -1, 24);
    check("t3_sum1", sums.size() > 1 ? sums[1] : -1, 24);
    check("t3_gap", min_gap, 3);
    clear_mon();
    for (int i = 0; i < 5; i++) push(4'h2);
    in_valid = 0;
    for (int i = 0; i < 50 && fen < 2; i++) tick(1);
    check("t4_feeding", int'(busy), 1);
    Rst = 1;
    tick(1);
    reset_outputs("midrst");
    Rst = 0;
    tick(12);
    check("t4_no_done", sums.size(), 0);
    check("t4_idle", int'(busy), 0);
    clear_mon();
    for (int i = 0; i < 8; i++) push(4'h1);
    in_valid = 0;
    wait_frames(1);
    check("t4_sum", sums.size() > 0 ? sums[0] : -1, 8);
    clear_mon();
    push(4'd1); push(4'd0); push(4'd2); push(4'd0); push(4'd3);
    push(4'd4); push(4'd5); push(4'd6); push(4'd7); push(4'd8);
    in_valid = 0;
    wait_frames(1);
`ifdef NIBBLE_FEEDER_ZERO_SKIP_EN
    check("t5_log", sums.size() > 0 ? int'(logs[0]) : -1, 32'h12345678);
    check("t5_sum", sums.size() > 0 ? sums[0] : -1, 36);
`else
    check("t5_log", sums.size() > 0 ? int'(logs[0]) : -1, 32'h10203456);
    check("t5_sum", sums.size() > 0 ? sums[0] : -1, 21);
`endif
    check("t5_en", sums.size() > 0 ? ens[0] : -1, 8);
    Rst = 1;
    tick(1);
    Rst = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nibble_feeder.md
# nibble_feeder

Input staging stage directly upstream of the 16-bit accumulator register. Buffers 4-bit samples from a valid/ready source in a small FIFO, then feeds them one per cycle to the accumulator as frames of FRAME_LEN nibbles. Each frame is bracketed by a clear strobe and a completion strobe. The accumulator's zero-extended add (4-bit `ln` into a 16-bit running sum) consumes `ln`/`acc_en`/`acc_clr` directly.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- FRAME_LEN, 8: nibbles per frame; 2..255.
- clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  reset, synchronous, active-high.
- in_data  in  4  sample nibble.
- in_valid  in  1  source has a sample.
- in_ready  out  1  FIFO can accept; = !full && !Rst.
- hold  in  1  downstream stall; while high no pop occurs.
- ln  out  4  nibble to accumulator; registered.
- acc_en  out  1  one-cycle strobe: add `ln` this cycle; registered.
- acc_clr  out  1  one-cycle strobe: clear accumulator.
- frame_done  out  1  one-cycle strobe: frame complete.
- fill_level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- busy  out  1  FSM not in IDLE.

## Operation
- FIFO: push when in_valid && in_ready. in_ready depends only on registered occupancy. At full, a same-cycle pop does not enable a push. Pointers wrap modulo DEPTH.
- FSM states: IDLE, CLEAR, FEED, DONE.
  - IDLE: fill_level≠0 → CLEAR; else stay.
  - CLEAR: acc_clr=1; frame counter ← 0; → FEED unconditionally.
  - FEED: pop when !empty && !hold. On a pop, ln ← head and acc_en ← 1 (next cycle), and counter increments. The pop that makes counter reach FRAME_LEN → DONE. Empty or hold: no pop, acc_en=0 next cycle, stay.
  - DONE: frame_done=1 → IDLE.
- acc_clr, frame_done, busy: decoded from the state register (Moore).
- ln holds its last value when acc_en=0.
- Occupancy: +1 on push only, −1 on pop only, unchanged on push+pop. Never exceeds DEPTH or drops below 0.
- Reset values: state IDLE, FIFO empty, pointers 0, counter 0, ln=0, acc_en=0, acc_clr=0, frame_done=0, busy=0, fill_level=0, in_ready=0 while Rst high.
- Reset mid-frame: everything returns to reset values in one edge; buffered nibbles are discarded; no frame_done is issued.

## Timing
- Nibble pushed at edge t is visible at t+1. From IDLE: CLEAR in cycle t+1→t+2, first pop in FEED cycle t+2→t+3, first acc_en/ln valid in cycle t+3→t+4.
- acc_clr always precedes the first acc_en of its frame by ≥2 cycles.
- The last acc_en of a frame is coincident with frame_done (DONE cycle). The accumulator sum is final one cycle after frame_done.
- Minimum gap between frames: DONE→IDLE→CLEAR→FEED, so 3 cycles with no acc_en.
- Throughput in FEED: one nibble/cycle when FIFO non-empty and hold low.
- hold asserted in cycle c blocks the pop at edge c; acc_en is low the following cycle.

## Configuration
- NIBBLE_FEEDER_ZERO_SKIP_EN
  - Defined: a popped nibble of value 0 is consumed but produces no acc_en and does not increment the frame counter. A frame therefore contains FRAME_LEN non-zero nibbles.
  - Undefined: zeros are fed and counted like any other value.

## Test plan
- Reset, then push 1..8 back-to-back (FRAME_LEN=8, hold=0) → one acc_clr, 8 acc_en with ln=1..8 in order, frame_done with the 8th; downstream sum=36 (0x0024).
- hold=1, push 0xF repeatedly → in_ready falls after 4 accepted, fill_level=4, 5th held off. Release hold → 4 acc_en with ln=0xF, in_ready high again one cycle after the first pop.
- Push 16 nibbles of 0x3 with FRAME_LEN=8 → two acc_clr, two frame_done, each frame sum=24, ≥3-cycle acc_en gap between frames.
- Push 5 nibbles, assert Rst one cycle during FEED → next cycle: all outputs at reset values, fill_level=0, no frame_done. New push of 8×0x1 yields sum=8.
- Macro defined, push 1,0,2,0,3,4,5,6,7,8 → 8 acc_en with ln=1..8 (zeros absent), frame_done on ln=8. Macro undefined, same stimulus → frame of 1,0,2,0,3,4,5,6, sum=21.
- Push at full with simultaneous pop (hold=0, FIFO full) → push refused, fill_level decrements by 1.
